// File: rtl/isa_pkg.sv
// ISA constants, fetch FSM state encoding and HALT decode shared by fetch and the control decoder.
// Pure declarations; no latency, no backpressure.
// HALT is identified by opcode and function field only, so the low nibble is free for the assembler.
package isa_pkg;

    localparam int ISA_IW = 9;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_BRANCH = 3'b100;
    localparam logic [OP_W-1:0] OP_RTYPE2 = 3'b111;
    localparam logic [1:0]      FN_HALT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } fetch_state_t;

    function automatic logic is_halt(input logic [ISA_IW-1:0] instr);
        return (instr[8:6] == OP_RTYPE2) && (instr[5:4] == FN_HALT);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: one synchronous write port and one asynchronous read port.
// Latency: a write becomes visible on the read port the cycle after it is accepted.
// No backpressure; a write is accepted on every cycle in which we is high.
module branch_lut #(
    parameter int LUT_W = 5,
    parameter int PC_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [LUT_W-1:0] widx,
    input  logic [PC_W-1:0]  wdata,
    input  logic [LUT_W-1:0] ridx,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem [2**LUT_W];

    // Unwritten entries must read as target 0, so every entry is cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**LUT_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: owns the PC, drives a synchronous ROM and redirects via the branch LUT.
// Latency: first valid instr two cycles after start; a taken branch costs exactly one bubble.
// Backpressure: stall holds instr, pc and rom_addr; branch and HALT are acted on only once stall drops.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int IW    = 9,
    parameter int PC_W  = 10,
    parameter int LUT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [IW-1:0]    rom_data,
    output logic [IW-1:0]    instr,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc,
    input  logic             stall,
    input  logic             branch,
    input  logic             branch_cond,
    input  logic             lut_we,
    input  logic [LUT_W-1:0] lut_widx,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic             done
);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

    fetch_state_t    state;
    logic            held;
    logic [IW-1:0]   hold_q;
    logic [PC_W-1:0] lut_rdata;
    logic            taken;
    logic            halt;

    // rom_addr already points at pc+1, so a stalled ROM would drift onto the next word;
    // the presented word is captured on the first stalled edge and replayed until release.
    assign instr = held ? hold_q : rom_data;
    assign taken = branch & branch_cond;
    assign halt  = is_halt(instr);

    branch_lut #(
        .LUT_W (LUT_W),
        .PC_W  (PC_W)
    ) u_branch_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .widx  (lut_widx),
        .wdata (lut_wdata),
        .ridx  (instr[LUT_W:1]),
        .rdata (lut_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            held        <= 1'b0;
            hold_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        state    <= PRIME;
                    end
                end
                PRIME: begin
                    rom_addr    <= rom_addr + PC_INC;
                    pc          <= '0;
                    instr_valid <= 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        if (!held) begin
                            held   <= 1'b1;
                            hold_q <= rom_data;
                        end
                    end else begin
                        held <= 1'b0;
                        // HALT wins over a spuriously raised branch flag.
                        if (halt) begin
                            instr_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (taken) begin
                            rom_addr    <= lut_rdata;
                            instr_valid <= 1'b0;
                            state       <= FLUSH;
                        end else begin
                            pc       <= rom_addr;
                            rom_addr <= rom_addr + PC_INC;
                        end
                    end
                end
                FLUSH: begin
                    pc          <= rom_addr;
                    rom_addr    <= rom_addr + PC_INC;
                    instr_valid <= 1'b1;
                    state       <= RUN;
                end
                DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        rom_addr <= '0;
                        state    <= PRIME;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table plus hand-written async-reset sequences.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stall, branch, branch_cond, lut_we;
    logic [4:0] lut_widx;
    logic [9:0] lut_wdata;
    logic [9:0] rom_addr, pc;
    logic [8:0] rom_data, instr;
    logic       instr_valid, done;

    logic [8:0] rom [1024];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       start, stall, br, cond, we;
        logic [4:0] widx;
        logic [9:0] wdata;
        logic       vld;
        logic [9:0] pc;
        logic       done;
    } vec_t;

    vec_t vt [31];

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .stall       (stall),
        .branch      (branch),
        .branch_cond (branch_cond),
        .lut_we      (lut_we),
        .lut_widx    (lut_widx),
        .lut_wdata   (lut_wdata),
        .done        (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, st, b, c, w, input int wi, wd,
                                input logic v, input int p, input logic d);
        vec_t r;
        r.start = s;  r.stall = st; r.br = b; r.cond = c; r.we = w;
        r.widx  = wi[4:0]; r.wdata = wd[9:0];
        r.vld   = v;  r.pc = p[9:0]; r.done = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_run(input string tag, input int exp_pc);
        chk({tag, " vld"},   32'(instr_valid), 32'd1);
        chk({tag, " pc"},    32'(pc), 32'(exp_pc));
        chk({tag, " instr"}, 32'(instr), 32'(rom[exp_pc]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, " pc"},       32'(pc), 32'd0);
        chk({tag, " vld"},      32'(instr_valid), 32'd0);
        chk({tag, " done"},     32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = {3'b001, i[5:0]};
        rom[5]  = 9'b100_00011_0;
        rom[9]  = 9'b111_11_0000;
        rom[21] = 9'b100_00111_0;

        //          st st br cd we wi wd   | vld pc  done
        vt[0]  = mk(1, 0, 0, 0, 1, 3, 20,    0,  0,  0);
        vt[1]  = mk(0, 0, 0, 0, 1, 7, 5,     0,  0,  0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0,     1,  0,  0);
        vt[3]  = mk(1, 0, 0, 0, 0, 0, 0,     1,  1,  0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 0,     1,  2,  0);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 0,     1,  3,  0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0,     1,  4,  0);
        vt[7]  = mk(0, 0, 1, 1, 1, 3, 30,    1,  5,  0);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0,     0,  5,  0);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0,     1,  20, 0);
        vt[10] = mk(0, 0, 1, 1, 0, 0, 0,     1,  21, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0,     0,  21, 0);
        vt[12] = mk(0, 0, 1, 0, 0, 0, 0,     1,  5,  0);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0,     1,  6,  0);
        vt[14] = mk(0, 1, 1, 1, 0, 0, 0,     1,  7,  0);
        vt[15] = mk(0, 1, 0, 0, 0, 0, 0,     1,  7,  0);
        vt[16] = mk(0, 1, 0, 0, 0, 0, 0,     1,  7,  0);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 0,     1,  7,  0);
        vt[18] = mk(0, 0, 0, 0, 0, 0, 0,     1,  8,  0);
        vt[19] = mk(0, 0, 1, 1, 0, 0, 0,     1,  9,  0);
        vt[20] = mk(0, 0, 0, 0, 0, 0, 0,     0,  9,  1);
        vt[21] = mk(1, 0, 0, 0, 0, 0, 0,     0,  9,  1);
        vt[22] = mk(0, 0, 0, 0, 0, 0, 0,     0,  9,  0);
        vt[23] = mk(0, 0, 0, 0, 0, 0, 0,     1,  0,  0);
        vt[24] = mk(0, 0, 0, 0, 0, 0, 0,     1,  1,  0);
        vt[25] = mk(0, 0, 0, 0, 0, 0, 0,     1,  2,  0);
        vt[26] = mk(0, 0, 0, 0, 0, 0, 0,     1,  3,  0);
        vt[27] = mk(0, 0, 0, 0, 0, 0, 0,     1,  4,  0);
        vt[28] = mk(0, 0, 1, 1, 0, 0, 0,     1,  5,  0);
        vt[29] = mk(0, 0, 0, 0, 0, 0, 0,     0,  5,  0);
        vt[30] = mk(0, 0, 0, 0, 0, 0, 0,     1,  30, 0);

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        lut_we = 1'b0; lut_widx = '0; lut_wdata = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("r%0d vld", i),  32'(instr_valid), 32'(vt[i].vld));
            chk($sformatf("r%0d done", i), 32'(done), 32'(vt[i].done));
            if (vt[i].vld) begin
                chk($sformatf("r%0d pc", i),    32'(pc), 32'(vt[i].pc));
                chk($sformatf("r%0d instr", i), 32'(instr), 32'(rom[vt[i].pc]));
            end
            start = vt[i].start; stall = vt[i].stall;
            branch = vt[i].br; branch_cond = vt[i].cond;
            lut_we = vt[i].we; lut_widx = vt[i].widx; lut_wdata = vt[i].wdata;
        end

        // Async reset mid-run, then restart and climb to pc 4.
        @(negedge clk);
        start = 1'b0; stall = 1'b0; branch = 1'b0; branch_cond = 1'b0; lut_we = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("midrun rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("prime vld", 32'(instr_valid), 32'd0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk_run($sformatf("seq1 k%0d", k), k);
        end

        // Reset lands at pc 4; outputs must clear before the next edge.
        #2 rst_n = 1'b0;
        #1 chk_reset("pc4 rst");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk_run($sformatf("seq2 k%0d", k), k);
        end
        branch = 1'b1; branch_cond = 1'b1;
        @(negedge clk);
        branch = 1'b0; branch_cond = 1'b0;
        chk("lut clr bubble", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk_run("lut clr target", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
